conv_out_writer: RTL



---
 rtl/conv_out_writer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/conv_out_writer.sv
// conv_out_writer: sink end of the convolution line/filter pipeline.
// Counts raster positions of one input frame, drops border positions whose
// FN x FN window was not yet full, and writes every remaining filter result
// into the output feature-map RAM at a dense, auto-incrementing address.
// Optional build macro: CONV_OUT_STRIDE2_EN (keep only every other valid
// column and row, giving a stride-2 output map).
module conv_out_writer #(
   parameter int WIDTH  = 10,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int FN     = 3,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              en,
   input  logic [WIDTH-1:0]  din,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] wr_count,
   output logic              overrun
);

   // Column counter only reaches IMG_W-1; the row counter steps to IMG_H
   // on the final position, so it gets room for that value.
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 0) ? $clog2(IMG_H + 1) : 1;

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(FN - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;

   logic accept;
   logic last_pos;
   logic pos_valid;
   logic arm;

   // A position is consumed only while running; start is honoured only in IDLE.
   assign accept   = (state == RUN) && en;
   assign arm      = (state == IDLE) && start;
   assign last_pos = (col == COL_LAST) && (row == ROW_LAST);

`ifdef CONV_OUT_STRIDE2_EN
   logic [COL_W-1:0] col_off;
   logic [ROW_W-1:0] row_off;

   // Window must be fully populated and sit on an even offset from the first full window.
   always_comb begin
      col_off   = col - COL_FIRST;
      row_off   = row - ROW_FIRST;
      pos_valid = (col >= COL_FIRST) && (row >= ROW_FIRST) &&
                  !col_off[0] && !row_off[0];
   end
`else
   // Window is fully populated once FN-1 columns and FN-1 lines have gone by.
   always_comb begin
      pos_valid = (col >= COL_FIRST) && (row >= ROW_FIRST);
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: arm on start, finish on the last raster position, DONE lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (accept && last_pos) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the state.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Raster position and output address counters; stalled whenever en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (arm) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
         if (pos_valid) begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   // The address counter already equals the number of words issued this frame.
   assign wr_count = addr;

   // Sticky overrun: any en outside RUN, including one coincident with start, wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (en && (state != RUN)) begin
         overrun <= 1'b1;
      end else if (arm) begin
         overrun <= 1'b0;
      end
   end

   // RAM write port, one cycle behind acceptance; address and data hold between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= accept && pos_valid;
         if (accept && pos_valid) begin
            mem_addr  <= addr;
            mem_wdata <= din;
         end
      end
   end

endmodule
